// File: rtl/qspis_wb_arb.sv
// Two-master Wishbone arbiter (m0 = QSPI bridge, m1 = host) with round-robin grant
// and a stalled-access timeout that aborts with an error to the owning master.
module qspis_wb_arb #(
  parameter int unsigned TMO_CYCLES = 255
) (
  input  logic        sys_clk,
  input  logic        rst_n,
  input  logic        m0_cyc_i,
  input  logic        m0_stb_i,
  input  logic [31:0] m0_adr_i,
  input  logic        m0_we_i,
  input  logic [31:0] m0_dat_i,
  input  logic [3:0]  m0_sel_i,
  output logic [31:0] m0_dat_o,
  output logic        m0_ack_o,
  output logic        m0_err_o,
  input  logic        m1_cyc_i,
  input  logic        m1_stb_i,
  input  logic [31:0] m1_adr_i,
  input  logic        m1_we_i,
  input  logic [31:0] m1_dat_i,
  input  logic [3:0]  m1_sel_i,
  output logic [31:0] m1_dat_o,
  output logic        m1_ack_o,
  output logic        m1_err_o,
  output logic        s_cyc_o,
  output logic        s_stb_o,
  output logic [31:0] s_adr_o,
  output logic        s_we_o,
  output logic [31:0] s_dat_o,
  output logic [3:0]  s_sel_o,
  input  logic [31:0] s_dat_i,
  input  logic        s_ack_i,
  input  logic        s_err_i,
  output logic [1:0]  gnt_o,
  output logic        tmo_evt_o
);

  localparam int unsigned CNT_W = 16;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_GNT0  = 2'd1,
    ST_GNT1  = 2'd2,
    ST_ABORT = 2'd3
  } state_e;

  state_e           state_q, state_d;
  logic             owner_q, owner_d;
  logic             last_q, last_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [1:0]       gnt_q, gnt_d;

  logic             x_cyc, x_stb, x_we;
  logic [31:0]      x_adr, x_dat;
  logic [3:0]       x_sel;
  logic             r_ack, r_err;
  logic [31:0]      r_dat;

  // Request view of whichever master currently owns (or owned, in ABORT) the bus
  assign x_cyc = owner_q ? m1_cyc_i : m0_cyc_i;
  assign x_stb = owner_q ? m1_stb_i : m0_stb_i;
  assign x_we  = owner_q ? m1_we_i  : m0_we_i;
  assign x_adr = owner_q ? m1_adr_i : m0_adr_i;
  assign x_dat = owner_q ? m1_dat_i : m0_dat_i;
  assign x_sel = owner_q ? m1_sel_i : m0_sel_i;

  always_ff @(posedge sys_clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      owner_q <= 1'b0;
      last_q  <= 1'b1;
      cnt_q   <= '0;
      gnt_q   <= 2'b00;
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
      last_q  <= last_d;
      cnt_q   <= cnt_d;
      gnt_q   <= gnt_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    owner_d   = owner_q;
    last_d    = last_q;
    cnt_d     = '0;
    gnt_d     = 2'b00;
    s_cyc_o   = 1'b0;
    s_stb_o   = 1'b0;
    s_adr_o   = '0;
    s_we_o    = 1'b0;
    s_dat_o   = '0;
    s_sel_o   = '0;
    r_ack     = 1'b0;
    r_err     = 1'b0;
    r_dat     = '0;
    tmo_evt_o = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        // On contention the master that did not own the bus last wins
        if (m0_cyc_i && (!m1_cyc_i || last_q)) begin
          state_d = ST_GNT0;
          owner_d = 1'b0;
        end else if (m1_cyc_i) begin
          state_d = ST_GNT1;
          owner_d = 1'b1;
        end
      end

      ST_GNT0, ST_GNT1: begin
        if (!x_cyc) begin
          state_d = ST_IDLE;
          last_d  = owner_q;
        end else begin
          s_cyc_o = 1'b1;
          s_stb_o = x_stb;
          s_adr_o = x_adr;
          s_we_o  = x_we;
          s_dat_o = x_dat;
          s_sel_o = x_sel;
          r_dat   = s_dat_i;
          if (x_stb && !s_ack_i && !s_err_i) begin
            if (cnt_q == CNT_W'(TMO_CYCLES)) begin
              s_cyc_o   = 1'b0;
              s_stb_o   = 1'b0;
              r_err     = 1'b1;
              tmo_evt_o = 1'b1;
              state_d   = ST_ABORT;
            end else begin
              cnt_d = cnt_q + CNT_W'(1);
            end
          end else begin
            r_ack = s_ack_i;
            r_err = s_err_i;
          end
        end
      end

      ST_ABORT: begin
        // Slave is ignored until the master withdraws its strobe
        if (!x_stb) begin
          if (x_cyc) begin
            state_d = owner_q ? ST_GNT1 : ST_GNT0;
          end else begin
            state_d = ST_IDLE;
            last_d  = owner_q;
          end
        end
      end

      default: state_d = ST_IDLE;
    endcase

    unique case (state_d)
      ST_GNT0:  gnt_d = 2'b01;
      ST_GNT1:  gnt_d = 2'b10;
      ST_ABORT: gnt_d = owner_d ? 2'b10 : 2'b01;
      default:  gnt_d = 2'b00;
    endcase
  end

  assign m0_ack_o = r_ack & ~owner_q;
  assign m0_err_o = r_err & ~owner_q;
  assign m0_dat_o = owner_q ? 32'h0 : r_dat;
  assign m1_ack_o = r_ack & owner_q;
  assign m1_err_o = r_err & owner_q;
  assign m1_dat_o = owner_q ? r_dat : 32'h0;
  assign gnt_o    = gnt_q;

endmodule

// File: tb/tb_qspis_wb_arb.sv
// Directed bench for qspis_wb_arb: grant, round-robin, timeout, back-to-back, error and reset cases.
module tb_qspis_wb_arb;

  localparam int unsigned TMO = 16;

  logic        sys_clk = 1'b0;
  logic        rst_n;
  logic        m0_cyc_i, m0_stb_i, m0_we_i;
  logic [31:0] m0_adr_i, m0_dat_i, m0_dat_o;
  logic [3:0]  m0_sel_i;
  logic        m0_ack_o, m0_err_o;
  logic        m1_cyc_i, m1_stb_i, m1_we_i;
  logic [31:0] m1_adr_i, m1_dat_i, m1_dat_o;
  logic [3:0]  m1_sel_i;
  logic        m1_ack_o, m1_err_o;
  logic        s_cyc_o, s_stb_o, s_we_o;
  logic [31:0] s_adr_o, s_dat_o, s_dat_i;
  logic [3:0]  s_sel_o;
  logic        s_ack_i, s_err_i;
  logic [1:0]  gnt_o;
  logic        tmo_evt_o;

  int errors = 0;
  int checks = 0;

  qspis_wb_arb #(.TMO_CYCLES(TMO)) dut (
    .sys_clk(sys_clk), .rst_n(rst_n),
    .m0_cyc_i(m0_cyc_i), .m0_stb_i(m0_stb_i), .m0_adr_i(m0_adr_i), .m0_we_i(m0_we_i),
    .m0_dat_i(m0_dat_i), .m0_sel_i(m0_sel_i), .m0_dat_o(m0_dat_o), .m0_ack_o(m0_ack_o),
    .m0_err_o(m0_err_o),
    .m1_cyc_i(m1_cyc_i), .m1_stb_i(m1_stb_i), .m1_adr_i(m1_adr_i), .m1_we_i(m1_we_i),
    .m1_dat_i(m1_dat_i), .m1_sel_i(m1_sel_i), .m1_dat_o(m1_dat_o), .m1_ack_o(m1_ack_o),
    .m1_err_o(m1_err_o),
    .s_cyc_o(s_cyc_o), .s_stb_o(s_stb_o), .s_adr_o(s_adr_o), .s_we_o(s_we_o),
    .s_dat_o(s_dat_o), .s_sel_o(s_sel_o), .s_dat_i(s_dat_i), .s_ack_i(s_ack_i),
    .s_err_i(s_err_i), .gnt_o(gnt_o), .tmo_evt_o(tmo_evt_o)
  );

  always #5 sys_clk = ~sys_clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic nxt();
    @(posedge sys_clk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic idle_all();
    m0_cyc_i = 1'b0; m0_stb_i = 1'b0; m0_we_i = 1'b0; m0_adr_i = '0; m0_dat_i = '0; m0_sel_i = '0;
    m1_cyc_i = 1'b0; m1_stb_i = 1'b0; m1_we_i = 1'b0; m1_adr_i = '0; m1_dat_i = '0; m1_sel_i = '0;
    s_dat_i = '0; s_ack_i = 1'b0; s_err_i = 1'b0;
  endtask

  task automatic m0_req(input logic [31:0] adr, input logic we, input logic [31:0] dat,
                        input logic [3:0] sel);
    m0_cyc_i = 1'b1; m0_stb_i = 1'b1; m0_adr_i = adr; m0_we_i = we; m0_dat_i = dat; m0_sel_i = sel;
  endtask

  task automatic m1_req(input logic [31:0] adr, input logic we, input logic [31:0] dat,
                        input logic [3:0] sel);
    m1_cyc_i = 1'b1; m1_stb_i = 1'b1; m1_adr_i = adr; m1_we_i = we; m1_dat_i = dat; m1_sel_i = sel;
  endtask

  task automatic m0_drop();
    m0_cyc_i = 1'b0; m0_stb_i = 1'b0;
  endtask

  task automatic m1_drop();
    m1_cyc_i = 1'b0; m1_stb_i = 1'b0;
  endtask

  task automatic do_reset();
    idle_all();
    rst_n = 1'b0;
    #12;
    rst_n = 1'b1;
    nxt();
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    rst_n = 1'b0;
    idle_all();

    // Reset state and single m0 write
    do_reset();
    chk("rst_gnt", 32'(gnt_o), 0);
    chk("rst_cyc", 32'(s_cyc_o), 0);
    chk("rst_stb", 32'(s_stb_o), 0);
    chk("rst_evt", 32'(tmo_evt_o), 0);
    chk("rst_adr", s_adr_o, 0);
    m0_req(32'h0000_1000, 1'b1, 32'hA5A5_5A5A, 4'hF);
    settle();
    chk("t1_latency_cyc", 32'(s_cyc_o), 0);
    nxt();
    chk("t1_gnt", 32'(gnt_o), 1);
    chk("t1_cyc", 32'(s_cyc_o), 1);
    chk("t1_stb", 32'(s_stb_o), 1);
    chk("t1_adr", s_adr_o, 32'h0000_1000);
    chk("t1_dat", s_dat_o, 32'hA5A5_5A5A);
    chk("t1_sel", 32'(s_sel_o), 32'hF);
    chk("t1_we", 32'(s_we_o), 1);
    nxt(); nxt(); nxt();
    s_ack_i = 1'b1; s_dat_i = 32'hDEAD_BEEF;
    settle();
    chk("t1_m0_ack", 32'(m0_ack_o), 1);
    chk("t1_m1_ack", 32'(m1_ack_o), 0);
    chk("t1_m1_dat", m1_dat_o, 0);
    nxt();
    s_ack_i = 1'b0; m0_drop();
    settle();
    chk("t1_ack_once", 32'(m0_ack_o), 0);
    chk("t1_cyc_drop", 32'(s_cyc_o), 0);
    nxt();
    chk("t1_idle_gnt", 32'(gnt_o), 0);

    // Round-robin contention: m0, m1, m0 with an idle gap between owners
    do_reset();
    m0_req(32'h100, 1'b0, 32'h0, 4'hF);
    m1_req(32'h200, 1'b0, 32'h0, 4'hF);
    settle();
    nxt();
    chk("t2_r1_gnt", 32'(gnt_o), 1);
    chk("t2_r1_adr", s_adr_o, 32'h100);
    s_ack_i = 1'b1;
    settle();
    chk("t2_r1_m0_ack", 32'(m0_ack_o), 1);
    chk("t2_r1_m1_ack", 32'(m1_ack_o), 0);
    nxt();
    s_ack_i = 1'b0; m0_drop();
    settle();
    nxt();
    chk("t2_gap1_gnt", 32'(gnt_o), 0);
    chk("t2_gap1_cyc", 32'(s_cyc_o), 0);
    m0_req(32'h104, 1'b0, 32'h0, 4'hF);
    nxt();
    chk("t2_r2_gnt", 32'(gnt_o), 2);
    chk("t2_r2_adr", s_adr_o, 32'h200);
    s_ack_i = 1'b1; s_dat_i = 32'h0000_1234;
    settle();
    chk("t2_r2_m1_ack", 32'(m1_ack_o), 1);
    chk("t2_r2_m1_dat", m1_dat_o, 32'h0000_1234);
    chk("t2_r2_m0_ack", 32'(m0_ack_o), 0);
    chk("t2_r2_m0_dat", m0_dat_o, 0);
    nxt();
    s_ack_i = 1'b0; m1_drop();
    settle();
    nxt();
    chk("t2_gap2_gnt", 32'(gnt_o), 0);
    nxt();
    chk("t2_r3_gnt", 32'(gnt_o), 1);
    chk("t2_r3_adr", s_adr_o, 32'h104);
    s_ack_i = 1'b1;
    settle();
    nxt();
    s_ack_i = 1'b0; m0_drop();
    settle();
    nxt();

    // m1 read that the slave never answers
    m1_req(32'h3000, 1'b0, 32'h0, 4'hF);
    settle();
    nxt();
    chk("t3_gnt", 32'(gnt_o), 2);
    chk("t3_stb", 32'(s_stb_o), 1);
    for (int k = 0; k < int'(TMO); k++) begin
      chk("t3_early_err", 32'(m1_err_o), 0);
      chk("t3_early_evt", 32'(tmo_evt_o), 0);
      nxt();
    end
    chk("t3_err", 32'(m1_err_o), 1);
    chk("t3_evt", 32'(tmo_evt_o), 1);
    chk("t3_stb_forced", 32'(s_stb_o), 0);
    chk("t3_cyc_forced", 32'(s_cyc_o), 0);
    chk("t3_m0_err", 32'(m0_err_o), 0);
    nxt();
    chk("t3_evt_pulse", 32'(tmo_evt_o), 0);
    chk("t3_err_pulse", 32'(m1_err_o), 0);
    chk("t3_abort_stb", 32'(s_stb_o), 0);
    chk("t3_abort_gnt", 32'(gnt_o), 2);
    s_ack_i = 1'b1;
    settle();
    chk("t3_late_ack", 32'(m1_ack_o), 0);
    nxt();
    s_ack_i = 1'b0; m1_drop();
    settle();
    nxt();
    chk("t3_idle_gnt", 32'(gnt_o), 0);

    // m0 back-to-back reads while m1 waits
    m0_req(32'h2000, 1'b0, 32'h0, 4'hF);
    settle();
    nxt();
    chk("t4_gnt", 32'(gnt_o), 1);
    m1_req(32'h4000, 1'b0, 32'h0, 4'hF);
    for (int i = 0; i < 4; i++) begin
      m0_adr_i = 32'h2000 + 32'(i * 4);
      s_ack_i = 1'b1; s_dat_i = 32'h1111_0000 + 32'(i);
      settle();
      chk("t4_adr", s_adr_o, 32'h2000 + 32'(i * 4));
      chk("t4_m0_dat", m0_dat_o, 32'h1111_0000 + 32'(i));
      chk("t4_m0_ack", 32'(m0_ack_o), 1);
      chk("t4_m1_ack", 32'(m1_ack_o), 0);
      chk("t4_hold_gnt", 32'(gnt_o), 1);
      nxt();
    end
    s_ack_i = 1'b0; m0_drop();
    settle();
    chk("t4_drop_cyc", 32'(s_cyc_o), 0);
    nxt();
    chk("t4_gap_gnt", 32'(gnt_o), 0);
    nxt();
    chk("t4_m1_gnt", 32'(gnt_o), 2);
    chk("t4_m1_adr", s_adr_o, 32'h4000);
    s_ack_i = 1'b1;
    settle();
    chk("t4_m1_ack", 32'(m1_ack_o), 1);
    nxt();
    s_ack_i = 1'b0; m1_drop();
    settle();
    nxt();

    // Slave error on m0, then a long wait proves the counter restarted
    m0_req(32'h5000, 1'b0, 32'h0, 4'hF);
    settle();
    nxt();
    chk("t5_gnt", 32'(gnt_o), 1);
    nxt(); nxt(); nxt();
    s_err_i = 1'b1;
    settle();
    chk("t5_m0_err", 32'(m0_err_o), 1);
    chk("t5_m0_ack", 32'(m0_ack_o), 0);
    chk("t5_evt", 32'(tmo_evt_o), 0);
    nxt();
    s_err_i = 1'b0;
    settle();
    chk("t5_err_once", 32'(m0_err_o), 0);
    for (int k = 1; k <= 14; k++) begin
      chk("t5_cnt_clear_evt", 32'(tmo_evt_o), 0);
      nxt();
    end
    s_ack_i = 1'b1; s_err_i = 1'b1;
    settle();
    chk("t5_both_ack", 32'(m0_ack_o), 1);
    chk("t5_both_err", 32'(m0_err_o), 1);
    chk("t5_both_evt", 32'(tmo_evt_o), 0);
    nxt();
    s_ack_i = 1'b0; s_err_i = 1'b0; m0_drop();
    settle();
    nxt();

    // Master abandons an access; the later slave ack goes nowhere
    m0_req(32'h6000, 1'b0, 32'h0, 4'hF);
    settle();
    nxt();
    chk("t6_cyc", 32'(s_cyc_o), 1);
    m0_drop();
    settle();
    chk("t6_drop_cyc", 32'(s_cyc_o), 0);
    nxt();
    s_ack_i = 1'b1;
    settle();
    chk("t6_late_ack", 32'(m0_ack_o), 0);
    chk("t6_idle_gnt", 32'(gnt_o), 0);
    nxt();
    s_ack_i = 1'b0;

    // Async reset while m1 owns the bus with stb pending
    m1_req(32'h7000, 1'b0, 32'h0, 4'hF);
    settle();
    nxt();
    chk("t7_gnt", 32'(gnt_o), 2);
    chk("t7_cyc", 32'(s_cyc_o), 1);
    #2;
    rst_n = 1'b0; s_ack_i = 1'b1;
    #1;
    chk("t7_rst_cyc", 32'(s_cyc_o), 0);
    chk("t7_rst_gnt", 32'(gnt_o), 0);
    chk("t7_rst_ack", 32'(m1_ack_o), 0);
    chk("t7_rst_err", 32'(m1_err_o), 0);
    #3;
    s_ack_i = 1'b0;
    m0_req(32'h8000, 1'b0, 32'h0, 4'hF);
    rst_n = 1'b1;
    nxt();
    chk("t7_m0_wins", 32'(gnt_o), 1);
    chk("t7_m0_adr", s_adr_o, 32'h8000);
    m0_drop(); m1_drop();
    nxt();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
